// File: rtl/sample_ctrl_mc.sv
// sample_ctrl_mc: per-channel two-phase handshake sampler with a timing-resiliency
// window, bounded re-sampling on error, and sticky fail/protocol flags.
// Ports: clk, rst (sync, active-high); req_i/hold_i/err_i per channel; clr_i clears
//   sticky flags; sample_o/retry_o one-cycle pulses; ack_o two-phase acknowledge;
//   fail_o/proto_err_o sticky flags. All outputs registered.
// Optional macro SAMPLE_SYNC_EN: two-flop synchronizers on req_i/hold_i/err_i (+2 cycles).
module sample_ctrl_mc #(
  parameter int N_CH      = 4,
  parameter int WIN       = 2,
  parameter int MAX_RETRY = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req_i,
  input  logic [N_CH-1:0] hold_i,
  input  logic [N_CH-1:0] err_i,
  input  logic            clr_i,
  output logic [N_CH-1:0] sample_o,
  output logic [N_CH-1:0] ack_o,
  output logic [N_CH-1:0] retry_o,
  output logic [N_CH-1:0] fail_o,
  output logic [N_CH-1:0] proto_err_o
);

  localparam logic [3:0] WIN_LD = 4'(WIN - 1);
  localparam logic [2:0] MAX_R  = 3'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, SAMPLE, WINDOW} state_t;

  state_t          state     [N_CH];
  state_t          state_nxt [N_CH];
  logic [3:0]      win_cnt       [N_CH];
  logic [3:0]      win_cnt_nxt   [N_CH];
  logic [2:0]      retry_cnt     [N_CH];
  logic [2:0]      retry_cnt_nxt [N_CH];
  logic [N_CH-1:0] sample_nxt, ack_nxt, retry_nxt, fail_nxt, proto_nxt;
  logic [N_CH-1:0] req_use, hold_use, err_use;
  logic [N_CH-1:0] req_prev;

`ifdef SAMPLE_SYNC_EN
  logic [N_CH-1:0] req_s1, req_s2, hold_s1, hold_s2, err_s1, err_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_s1  <= '0;
      req_s2  <= '0;
      hold_s1 <= '0;
      hold_s2 <= '0;
      err_s1  <= '0;
      err_s2  <= '0;
    end else begin
      req_s1  <= req_i;
      req_s2  <= req_s1;
      hold_s1 <= hold_i;
      hold_s2 <= hold_s1;
      err_s1  <= err_i;
      err_s2  <= err_s1;
    end
  end

  assign req_use  = req_s2;
  assign hold_use = hold_s2;
  assign err_use  = err_s2;
`else
  assign req_use  = req_i;
  assign hold_use = hold_i;
  assign err_use  = err_i;
`endif

  always_comb begin
    sample_nxt = '0;
    retry_nxt  = '0;
    ack_nxt    = ack_o;
    // Clear first so that a set event in the same cycle wins.
    fail_nxt   = fail_o & ~{N_CH{clr_i}};
    proto_nxt  = proto_err_o & ~{N_CH{clr_i}};
    for (int i = 0; i < N_CH; i++) begin
      state_nxt[i]     = state[i];
      win_cnt_nxt[i]   = win_cnt[i];
      retry_cnt_nxt[i] = retry_cnt[i];

      // Any req edge while a token is in flight is a protocol violation.
      if (state[i] != IDLE && req_use[i] != req_prev[i]) begin
        proto_nxt[i] = 1'b1;
      end

      case (state[i])
        IDLE: begin
          if ((req_use[i] ^ ack_o[i]) && !hold_use[i]) begin
            state_nxt[i]  = SAMPLE;
            sample_nxt[i] = 1'b1;
          end
        end
        SAMPLE: begin
          win_cnt_nxt[i] = WIN_LD;
          state_nxt[i]   = WINDOW;
        end
        WINDOW: begin
          if (win_cnt[i] != 4'd0) begin
            win_cnt_nxt[i] = win_cnt[i] - 4'd1;
          end else if (!err_use[i]) begin
            ack_nxt[i]       = ~ack_o[i];
            retry_cnt_nxt[i] = '0;
            state_nxt[i]     = IDLE;
          end else if (retry_cnt[i] < MAX_R) begin
            retry_cnt_nxt[i] = retry_cnt[i] + 3'd1;
            sample_nxt[i]    = 1'b1;
            retry_nxt[i]     = 1'b1;
            state_nxt[i]     = SAMPLE;
          end else begin
            // Retries exhausted: flag it but still pass the token on.
            fail_nxt[i]      = 1'b1;
            ack_nxt[i]       = ~ack_o[i];
            retry_cnt_nxt[i] = '0;
            state_nxt[i]     = IDLE;
          end
        end
        default: state_nxt[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        state[i]     <= IDLE;
        win_cnt[i]   <= '0;
        retry_cnt[i] <= '0;
      end
      sample_o    <= '0;
      ack_o       <= '0;
      retry_o     <= '0;
      fail_o      <= '0;
      proto_err_o <= '0;
      req_prev    <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state[i]     <= state_nxt[i];
        win_cnt[i]   <= win_cnt_nxt[i];
        retry_cnt[i] <= retry_cnt_nxt[i];
      end
      sample_o    <= sample_nxt;
      ack_o       <= ack_nxt;
      retry_o     <= retry_nxt;
      fail_o      <= fail_nxt;
      proto_err_o <= proto_nxt;
      req_prev    <= req_use;
    end
  end

endmodule
